// File: rtl/sram_pkg.sv
// Shared widths, pipeline latencies and FSM encoding for the pipelined SRAM controller.
package sram_pkg;
  localparam int SRAM_ADDR_W     = 18;
  localparam int SRAM_DATA_W     = 32;
  localparam int SRAM_MASK_W     = SRAM_DATA_W / 8;
  localparam int ADDR_TO_DATA    = 2;
  localparam int ACCEPT_TO_VALID = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_state_e;
endpackage

// File: rtl/sram_op_pipe.sv
// Delay line carrying {is_read, is_write, wdata} from the command stage to the data stage.
module sram_op_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = ADDR_TO_DATA
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rd_o,
  output logic              wr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o
);
  logic [DEPTH-1:0]  rd_q;
  logic [DEPTH-1:0]  wr_q;
  logic [DATA_W-1:0] wdata_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
      wr_q <= '0;
      for (int i = 0; i < DEPTH; i++) wdata_q[i] <= '0;
    end else begin
      rd_q[0]    <= rd_i;
      wr_q[0]    <= wr_i;
      wdata_q[0] <= wdata_i;
      for (int i = 1; i < DEPTH; i++) begin
        rd_q[i]    <= rd_q[i-1];
        wr_q[i]    <= wr_q[i-1];
        wdata_q[i] <= wdata_q[i-1];
      end
    end
  end

  assign rd_o    = rd_q[DEPTH-1];
  assign wr_o    = wr_q[DEPTH-1];
  assign wdata_o = wdata_q[DEPTH-1];
  assign busy_o  = |(rd_q | wr_q);
endmodule

// File: rtl/sram_controller.sv
// Pipelined synchronous SRAM controller: one request per cycle, writes drive dq two cycles
// after the command, reads return three cycles after acceptance.
module sram_controller
  import sram_pkg::*;
#(
  parameter int  ADDR_W      = SRAM_ADDR_W,
  parameter int  DATA_W      = SRAM_DATA_W,
  parameter int  INIT_CYCLES = 16,
  localparam int MASK_W      = DATA_W / 8
) (
  input  logic              sram_clock,
  input  logic              reset_n,
  input  logic              sram_addr_valid,
  output logic              sram_ready,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_data_in,
  input  logic [MASK_W-1:0] sram_write_mask,
  output logic [DATA_W-1:0] sram_data_out,
  output logic              sram_data_out_valid,
  output logic              sram_pin_ce_n,
  output logic              sram_pin_we_n,
  output logic [MASK_W-1:0] sram_pin_bw_n,
  output logic [ADDR_W-1:0] sram_pin_addr,
  output logic [DATA_W-1:0] sram_pin_dq_out,
  output logic              sram_pin_dq_oe,
  input  logic [DATA_W-1:0] sram_pin_dq_in,
  output logic              busy,
  output logic              fsm_state_dbg
);
  localparam int             CNT_W     = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

  // Handshake: a request transfers on a rising edge where sram_addr_valid && sram_ready.
  sram_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, is_wr;
  logic              ce_n_q, we_n_q, cmd_rd_q, cmd_wr_q;
  logic [MASK_W-1:0] bw_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              rvalid_q;
  logic              pipe_rd, pipe_wr, pipe_busy;
  logic [DATA_W-1:0] pipe_wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sram_ready    = (state_q == ST_RUN);
  assign fsm_state_dbg = state_q;
  assign accept        = sram_addr_valid & sram_ready;
  assign is_wr         = |sram_write_mask;

  // Command pins are registered; an all-zero mask yields bw_n all-ones, i.e. a read.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      bw_n_q   <= '1;
      addr_q   <= '0;
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      ce_n_q   <= ~accept;
      we_n_q   <= ~(accept & is_wr);
      bw_n_q   <= accept ? ~sram_write_mask : '1;
      cmd_rd_q <= accept & ~is_wr;
      cmd_wr_q <= accept & is_wr;
      if (accept) begin
        addr_q  <= sram_addr;
        wdata_q <= sram_data_in;
      end
    end
  end

  sram_op_pipe #(
    .DATA_W(DATA_W),
    .DEPTH (ADDR_TO_DATA)
  ) u_op_pipe (
    .clk_i  (sram_clock),
    .rst_ni (reset_n),
    .rd_i   (cmd_rd_q),
    .wr_i   (cmd_wr_q),
    .wdata_i(wdata_q),
    .rd_o   (pipe_rd),
    .wr_o   (pipe_wr),
    .wdata_o(pipe_wdata),
    .busy_o (pipe_busy)
  );

  // The SRAM drives dq_in during the read's data phase; capture it on the closing edge.
  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= pipe_rd;
      if (pipe_rd) rdata_q <= sram_pin_dq_in;
    end
  end

  assign sram_pin_ce_n       = ce_n_q;
  assign sram_pin_we_n       = we_n_q;
  assign sram_pin_bw_n       = bw_n_q;
  assign sram_pin_addr       = addr_q;
  assign sram_pin_dq_out     = pipe_wdata;
  assign sram_pin_dq_oe      = pipe_wr;
  assign sram_data_out       = rdata_q;
  assign sram_data_out_valid = rvalid_q;
  assign busy                = cmd_rd_q | cmd_wr_q | pipe_busy;
endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter ADDR_W, default 18, word address width.
REQ-002 Parameter DATA_W, default 32, data width; MASK_W = DATA_W/8.
REQ-003 Parameter INIT_CYCLES, default 16, power-up wait in cycles before first request is accepted.
REQ-004 Port sram_clock  in  1  sole clock; all logic on its rising edge.
REQ-005 Port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 Port sram_addr_valid  in  1  request valid from arbiter.
REQ-007 Port sram_ready  out  1  controller can accept a request this cycle.
REQ-008 Port sram_addr  in  ADDR_W  request word address.
REQ-009 Port sram_data_in  in  DATA_W  write data.
REQ-010 Port sram_write_mask  in  MASK_W  byte-write enables; all-zero means read.
REQ-011 Port sram_data_out  out  DATA_W  read data.
REQ-012 Port sram_data_out_valid  out  1  one-cycle read-data strobe.
REQ-013 Ports sram_pin_ce_n out 1, sram_pin_we_n out 1, sram_pin_bw_n out MASK_W, sram_pin_addr out ADDR_W  registered pipelined-SRAM command pins.
REQ-014 Ports sram_pin_dq_out out DATA_W, sram_pin_dq_oe out 1, sram_pin_dq_in in DATA_W  split data bus; tristate is at top level.
REQ-015 Port busy  out  1  high while any accepted operation is still in the pipeline.

Function
REQ-016 The FSM SHALL have states INIT and RUN; INIT counts INIT_CYCLES cycles then moves to RUN; RUN is held until reset.
REQ-017 sram_ready SHALL be high only in RUN; it has no other backpressure, so one request per cycle is sustained.
REQ-018 A request SHALL be accepted at edge T when sram_addr_valid and sram_ready are both high; inputs are ignored otherwise.
REQ-019 On acceptance at T, pins SHALL show the command after edge T: ce_n=0, addr=sram_addr, we_n=(mask==0), bw_n=~mask for writes, bw_n all-ones for reads.
REQ-020 In cycles with no acceptance, pins SHALL show ce_n=1, we_n=1, and bw_n all-ones; the address holds its last value.
REQ-021 For a write accepted at T, dq_out SHALL equal the captured write data and dq_oe SHALL be 1 for exactly the cycle after edge T+2.
REQ-022 For a read accepted at T, sram_pin_dq_in SHALL be sampled at edge T+3 into sram_data_out, and sram_data_out_valid SHALL be 1 for the cycle after edge T+3 only.
REQ-023 sram_data_out SHALL hold its last read value when valid is low.
REQ-024 Back-to-back mixed operations, including read-after-write to the same address, SHALL each keep their own fixed latency without inserted bubbles; data coherence is the SRAM's responsibility.
REQ-025 A write mask with partial bits SHALL be passed through unchanged on bw_n, inverted.
REQ-026 busy SHALL be high from edge T until the last operation's data phase completes (after edge T+3).

Reset
REQ-027 Asserting reset_n low SHALL immediately force: state INIT, init counter 0, sram_ready 0, ce_n 1, we_n 1, bw_n all-ones, dq_oe 0, sram_data_out_valid 0, sram_data_out 0, busy 0, pipeline cleared.
REQ-028 Reset mid-operation SHALL discard in-flight operations with no late strobes; after release, the full INIT_CYCLES wait repeats.

Structure
REQ-029 Package sram_pkg SHALL hold ADDR_W/DATA_W/MASK_W defaults, the latency constants (ADDR_TO_DATA=2, ACCEPT_TO_VALID=3), and the FSM state encoding.
REQ-030 One sub-module sram_op_pipe SHALL implement the parameterised delay line carrying {is_read, is_write, wdata} from command stage to data stage.

Verification
REQ-031 Hold reset_n low, release it -> sram_ready rises exactly 16 cycles later; no ce_n=0 before then.
REQ-032 Write addr 0x00010, data 0xDEADBEEF, mask 0xF at T -> pins ce_n=0, we_n=0, bw_n=0x0 after T; dq_out=0xDEADBEEF with dq_oe=1 only after T+2.
REQ-033 Read addr 0x00010 at T with the model returning 0xDEADBEEF -> sram_data_out=0xDEADBEEF and valid high one cycle after edge T+3.
REQ-034 Alternate W/R/W/R on consecutive cycles with mask 0x3 on writes -> bw_n=0xC; each read strobe lands 3 cycles after its request; no dq_oe overlap with read sampling.
REQ-035 Assert reset_n low at T+1 of an outstanding read -> valid never pulses, dq_oe=0, ready low for 16 cycles after release.
